// File: rtl/regfile_wb_queue.sv
// regfile_wb_queue: in-order write-back buffer in front of the 32x64 register file.
// Compile-time option: define REGFILE_WBQ_BYPASS_EN to build the read-bypass network.
// Ports:
//   clock, reset        single rising-edge clock, asynchronous active-high reset (flushes queue)
//   enq_valid/ready     write-back request handshake; enq_addr/enq_data are the request
//   hold                suppresses draining this cycle
//   W, DA, D            register file write port, driven from the head entry
//   SA, SB, A_rf, B_rf  register file read selects and raw read data
//   A, B                read data with still-pending writes overlaid
//   count, full, empty  occupancy status
module regfile_wb_queue #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 64
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     enq_valid,
   output logic                     enq_ready,
   input  logic [4:0]               enq_addr,
   input  logic [WIDTH-1:0]         enq_data,
   input  logic                     hold,
   output logic                     W,
   output logic [4:0]               DA,
   output logic [WIDTH-1:0]         D,
   input  logic [4:0]               SA,
   input  logic [4:0]               SB,
   input  logic [WIDTH-1:0]         A_rf,
   input  logic [WIDTH-1:0]         B_rf,
   output logic [WIDTH-1:0]         A,
   output logic [WIDTH-1:0]         B,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
   logic [AW-1:0]    head_q, head_d, tail_q, tail_d;
   logic [AW:0]      count_q, count_d;
   logic [4:0]       addr_q [DEPTH];
   logic [WIDTH-1:0] data_q [DEPTH];
   logic             enq_fire, deq_fire;
   assign full      = count_q == FULL_CNT;
   assign empty     = count_q == '0;
   assign count     = count_q;
   // Refusal while full holds even if the head drains this cycle: no pass-through.
   assign enq_ready = !full;
   assign enq_fire  = enq_valid && !full;
   assign deq_fire  = !empty && !hold;
   assign W         = deq_fire;
   // Forced to zero when empty so the register file never sees stale storage.
   assign DA        = empty ? 5'd0 : addr_q[head_q];
   assign D         = empty ? '0 : data_q[head_q];
   always_comb begin
      head_d  = deq_fire ? head_q + AW'(1) : head_q;
      tail_d  = enq_fire ? tail_q + AW'(1) : tail_q;
      count_d = (enq_fire && !deq_fire) ? count_q + 1'b1 :
                (deq_fire && !enq_fire) ? count_q - 1'b1 : count_q;
   end
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end
   // Payload storage needs no reset: validity is tracked by head/count alone.
   always_ff @(posedge clock) begin
      if (enq_fire) begin
         addr_q[tail_q] <= enq_addr;
         data_q[tail_q] <= enq_data;
      end
   end
`ifdef REGFILE_WBQ_BYPASS_EN
   // Walk oldest to newest so the newest matching pending entry wins; the head
   // being drained this cycle still counts as pending.
   always_comb begin
      A = A_rf;
      B = B_rf;
      for (int i = 0; i < DEPTH; i++) begin
         if (i < int'(count_q) && addr_q[head_q + AW'(i)] == SA) A = data_q[head_q + AW'(i)];
         if (i < int'(count_q) && addr_q[head_q + AW'(i)] == SB) B = data_q[head_q + AW'(i)];
      end
   end
`else
   logic unused_sel;
   assign unused_sel = ^{SA, SB};
   assign A = A_rf;
   assign B = B_rf;
`endif
endmodule

// File: tb/tb_regfile_wb_queue.sv
// tb_regfile_wb_queue: table vectors, corner sequences and a random run against a queue model.
module tb_regfile_wb_queue;
   logic        clock = 0, reset = 1;
   logic        enq_valid = 0, enq_ready, hold = 0, W, full, empty;
   logic [4:0]  enq_addr = 0, DA, SA = 0, SB = 0;
   logic [63:0] enq_data = 0, D, A_rf = 0, B_rf = 0, A, B;
   logic [2:0]  count;
   int checks = 0, errors = 0;
   logic [4:0]  qa[$];
   logic [63:0] qd[$];
   regfile_wb_queue #(.DEPTH(4), .WIDTH(64)) dut (
      .clock(clock), .reset(reset), .enq_valid(enq_valid), .enq_ready(enq_ready),
      .enq_addr(enq_addr), .enq_data(enq_data), .hold(hold), .W(W), .DA(DA), .D(D),
      .SA(SA), .SB(SB), .A_rf(A_rf), .B_rf(B_rf), .A(A), .B(B),
      .count(count), .full(full), .empty(empty));
   always #5 clock = ~clock;
   typedef struct {
      bit ev; logic [4:0] a; logic [63:0] d; bit h;
      int cnt; bit w; logic [4:0] da; logic [63:0] dd; bit rdy;
   } vec_t;
   vec_t vt[15];
   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask
   // Reference: a plain FIFO of pending writes; inputs are applied as of the edge.
   task automatic tick();
      bit pop, push;
      @(posedge clock);
      if (reset) begin
         qa.delete();
         qd.delete();
      end else begin
         pop  = qa.size() > 0 && !hold;
         push = enq_valid && qa.size() < 4;
         if (pop) begin
            void'(qa.pop_front());
            void'(qd.pop_front());
         end
         if (push) begin
            qa.push_back(enq_addr);
            qd.push_back(enq_data);
         end
      end
      #1;
   endtask
   function automatic logic [63:0] byp(input logic [4:0] sel, input logic [63:0] rf);
`ifdef REGFILE_WBQ_BYPASS_EN
      for (int i = qa.size() - 1; i >= 0; i--) if (qa[i] == sel) return qd[i];
`endif
      return rf;
   endfunction
   task automatic check_model(input string tag);
      int n;
      n = qa.size();
      chk({tag, ".count"}, 64'(count), 64'(n));
      chk({tag, ".empty"}, 64'(empty), 64'(n == 0));
      chk({tag, ".full"}, 64'(full), 64'(n == 4));
      chk({tag, ".enq_ready"}, 64'(enq_ready), 64'(n != 4));
      chk({tag, ".W"}, 64'(W), 64'(n > 0 && !hold));
      chk({tag, ".DA"}, 64'(DA), n > 0 ? 64'(qa[0]) : 64'd0);
      chk({tag, ".D"}, D, n > 0 ? qd[0] : 64'd0);
      chk({tag, ".A"}, A, byp(SA, A_rf));
      chk({tag, ".B"}, B, byp(SB, B_rf));
   endtask
   task automatic drive(input bit ev, input logic [4:0] a, input logic [63:0] d, input bit h);
      enq_valid = ev; enq_addr = a; enq_data = d; hold = h;
   endtask
   initial begin
      vt[0]  = '{1, 5, 64'h0123456789ABCDEF, 0, 0, 0, 0, 0, 1};
      vt[1]  = '{0, 0, 0, 0, 1, 1, 5, 64'h0123456789ABCDEF, 1};
      vt[2]  = '{0, 0, 0, 0, 0, 0, 0, 0, 1};
      vt[3]  = '{1, 1, 64'h11, 1, 0, 0, 0, 0, 1};
      vt[4]  = '{1, 2, 64'h22, 1, 1, 0, 1, 64'h11, 1};
      vt[5]  = '{1, 3, 64'h33, 1, 2, 0, 1, 64'h11, 1};
      vt[6]  = '{1, 4, 64'h44, 1, 3, 0, 1, 64'h11, 1};
      vt[7]  = '{1, 9, 64'h99, 1, 4, 0, 1, 64'h11, 0};
      vt[8]  = '{1, 9, 64'h99, 0, 4, 1, 1, 64'h11, 0};
      vt[9]  = '{1, 10, 64'hA0, 0, 3, 1, 2, 64'h22, 1};
      vt[10] = '{1, 11, 64'hB0, 0, 3, 1, 3, 64'h33, 1};
      vt[11] = '{0, 0, 0, 0, 3, 1, 4, 64'h44, 1};
      vt[12] = '{0, 0, 0, 0, 2, 1, 10, 64'hA0, 1};
      vt[13] = '{0, 0, 0, 0, 1, 1, 11, 64'hB0, 1};
      vt[14] = '{0, 0, 0, 0, 0, 0, 0, 0, 1};
      A_rf = 64'h5A5A; B_rf = 64'hC3C3;
      repeat (2) tick();
      reset = 0;
      @(negedge clock);
      check_model("reset");
      chk("reset.A", A, 64'h5A5A);
      tick();
      for (int i = 0; i < 15; i++) begin
         drive(vt[i].ev, vt[i].a, vt[i].d, vt[i].h);
         @(negedge clock);
         chk($sformatf("vec%0d.count", i), 64'(count), 64'(vt[i].cnt));
         chk($sformatf("vec%0d.W", i), 64'(W), 64'(vt[i].w));
         chk($sformatf("vec%0d.DA", i), 64'(DA), 64'(vt[i].da));
         chk($sformatf("vec%0d.D", i), D, vt[i].dd);
         chk($sformatf("vec%0d.enq_ready", i), 64'(enq_ready), 64'(vt[i].rdy));
         tick();
      end
      // Two pending writes to r7: the newer one must be visible.
      drive(1, 7, 64'hAA, 1); tick();
      drive(1, 7, 64'hBB, 1); tick();
      drive(0, 0, 0, 1);
      SA = 7; A_rf = 0; SB = 3; B_rf = 64'h5;
      #1;
`ifdef REGFILE_WBQ_BYPASS_EN
      chk("bypass.A_newest", A, 64'hBB);
`else
      chk("bypass.A_off", A, 64'h0);
`endif
      chk("bypass.B_miss", B, 64'h5);
      hold = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         check_model($sformatf("bydrain%0d", i));
         tick();
      end
      // Steady stream: one in, one out each cycle.
      for (int i = 0; i < 6; i++) begin
         drive(1, 5'(i + 20), 64'hF00 + 64'(i), 0);
         @(negedge clock);
         check_model($sformatf("stream%0d", i));
         if (i > 0) begin
            chk($sformatf("stream%0d.cnt1", i), 64'(count), 64'd1);
            chk($sformatf("stream%0d.D", i), D, 64'hF00 + 64'(i - 1));
         end
         tick();
      end
      drive(0, 0, 0, 0); tick(); tick();
      // Hold with two entries, then enqueue during hold.
      drive(1, 31, 64'h31, 1); tick();
      drive(1, 30, 64'h30, 1); tick();
      drive(0, 0, 0, 1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         chk($sformatf("hold%0d.W", i), 64'(W), 64'd0);
         chk($sformatf("hold%0d.count", i), 64'(count), 64'd2);
         tick();
      end
      drive(1, 29, 64'h29, 1); tick();
      @(negedge clock);
      chk("hold.count3", 64'(count), 64'd3);
      check_model("hold.after");
      // Asynchronous reset mid-cycle with three entries pending.
      drive(0, 0, 0, 0);
      #1;
      chk("prereset.W", 64'(W), 64'd1);
      reset = 1;
      #1;
      chk("areset.count", 64'(count), 64'd0);
      chk("areset.empty", 64'(empty), 64'd1);
      chk("areset.W", 64'(W), 64'd0);
      chk("areset.D", D, 64'd0);
      tick();
      reset = 0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clock);
         check_model($sformatf("postreset%0d", i));
         tick();
      end
      // Random traffic against the model.
      for (int i = 0; i < 400; i++) begin
         drive($urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0 ? 5'd31 : 5'($urandom_range(0, 7)),
               {$urandom, $urandom}, $urandom_range(0, 9) < 3);
         SA = 5'($urandom_range(0, 7)); SB = 5'($urandom_range(0, 7));
         A_rf = {$urandom, $urandom}; B_rf = {$urandom, $urandom};
         @(negedge clock);
         check_model($sformatf("rnd%0d", i));
         tick();
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
